// File: rtl/pc_gen.sv
// pc_gen: program-counter generator driving instruction fetch over a
// valid/ready handshake.
//
// The next PC is chosen by priority: trap vector, then branch/jump redirect,
// then the sequential step on an accepted fetch. The block supports
// halt/resume for debug and keeps a counter of accepted fetches.
//
// Optional feature, selected by the RVC_EN macro:
//   defined   - targets need 2-byte alignment; the step is 2 when
//               is_compressed is set, otherwise 4.
//   undefined - targets need 4-byte alignment; the step is always 4 and
//               is_compressed is ignored.

module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    // Redirect sources from the trap and EX logic
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             is_compressed,

    // Debug control
    input  logic             halt_req,
    input  logic             resume,

    // Fetch handshake
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pc_plus,

    // Status
    output logic             halted,
    output logic             misalign_err,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] fetch_count
);

    // Highest address bit that must be zero for a legal target
`ifdef RVC_EN
    localparam int unsigned AlignMsb = 0;
`else
    localparam int unsigned AlignMsb = 1;
`endif

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e           state_q;
    logic             fetch_valid_q;
    logic             halted_q;

    logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
    logic             misalign_q,    misalign_d;
    logic [XLEN-1:0]  bad_addr_q,    bad_addr_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [XLEN-1:0]  step;
    logic [XLEN-1:0]  pc_plus_w;
    logic             xfer;
    logic             req_pending;
    logic             trap_aligned;
    logic             redirect_aligned;

    // Sequential step size; a compressed instruction only shortens it with RVC_EN
`ifdef RVC_EN
    always_comb begin
        step = is_compressed ? XLEN'(2) : XLEN'(4);
    end
`else
    logic unused_is_compressed;
    assign unused_is_compressed = is_compressed;

    always_comb begin
        step = XLEN'(4);
    end
`endif

    // Wrap-around past the top of the address space is silent
    assign pc_plus_w = fetch_pc_q + step;

    assign xfer        = fetch_valid_q && fetch_ready;
    assign req_pending = fetch_valid_q && !fetch_ready;

    assign trap_aligned     = (trap_vector[AlignMsb:0] == '0);
    assign redirect_aligned = (redirect_target[AlignMsb:0] == '0);

    // Control FSM: state plus its registered fetch_valid/halted outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // Single idle cycle after reset release before fetching
                    state_q       <= StRun;
                    fetch_valid_q <= 1'b1;
                    halted_q      <= 1'b0;
                end
                StRun: begin
                    // Never abandon an outstanding request; halt once it is accepted
                    if (halt_req && !req_pending) begin
                        state_q       <= StHalt;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end
                end
                StHalt: begin
                    if (resume) begin
                        state_q       <= StRun;
                        fetch_valid_q <= 1'b1;
                        halted_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= StBoot;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    // Next-PC selection, misalignment capture and fetch counting
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        misalign_d    = 1'b0;
        bad_addr_d    = bad_addr_q;
        fetch_count_d = fetch_count_q;

        // An accepted fetch always counts, even when a redirect replaces the PC
        if (xfer) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end

        if (state_q != StBoot) begin
            if (trap_valid) begin
                // A bad trap vector also swallows any same-cycle redirect
                if (trap_aligned) begin
                    fetch_pc_d = trap_vector;
                end else begin
                    misalign_d = 1'b1;
                    bad_addr_d = trap_vector;
                end
            end else if (redirect_valid) begin
                // A bad redirect freezes the PC rather than stepping past it
                if (redirect_aligned) begin
                    fetch_pc_d = redirect_target;
                end else begin
                    misalign_d = 1'b1;
                    bad_addr_d = redirect_target;
                end
            end else if (xfer) begin
                fetch_pc_d = pc_plus_w;
            end
        end
    end

    // Datapath registers; reset also discards any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_VECTOR;
            misalign_q    <= 1'b0;
            bad_addr_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            misalign_q    <= misalign_d;
            bad_addr_q    <= bad_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_pc     = fetch_pc_q;
    assign pc_plus      = pc_plus_w;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign bad_addr     = bad_addr_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the fixed PC+4 adder.
- Holds the architectural fetch PC and drives instruction fetch over a valid/ready handshake.
- Selects the next PC by priority: trap vector, then branch/jump redirect, then sequential step.
- Supports halt/resume and a fetch counter; sits between the EX/trap logic and instruction memory.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trap_valid  in  1  trap request; highest priority.
- trap_vector  in  XLEN  trap handler address.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  branch/jump target.
- is_compressed  in  1  current fetched instruction is 16-bit; used only with RVC_EN.
- halt_req  in  1  request to pause fetch.
- resume  in  1  leave HALT.
- fetch_ready  in  1  instruction memory accepts the request.
- fetch_valid  out  1  fetch request valid.
- fetch_pc  out  XLEN  current PC.
- pc_plus  out  XLEN  fetch_pc + step (combinational).
- halted  out  1  state == HALT.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect/trap target.
- bad_addr  out  XLEN  last misaligned target.
- fetch_count  out  CNT_W  accepted-fetch counter.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_VECTOR; state=BOOT; fetch_valid=0; halted=0; misalign_err=0; bad_addr=0; fetch_count=0.
- States: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset release, fetch_valid=0, then moves to RUN.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1.
- Handshake:
  - A transfer occurs when fetch_valid && fetch_ready.
  - While fetch_valid=1 and fetch_ready=0, fetch_pc is held stable unless a trap or redirect flushes it.
- Step: 4. pc_plus = fetch_pc + step, modulo 2^XLEN. Wrap-around is silent: FFFF_FFFC+4 = 0000_0000.
- Next-PC priority, evaluated each edge in any state except BOOT:
  - trap_valid && aligned(trap_vector) -> fetch_pc <= trap_vector.
  - Else redirect_valid && aligned(redirect_target) -> fetch_pc <= redirect_target.
  - Else a transfer in RUN -> fetch_pc <= pc_plus.
  - Else hold.
- Simultaneous trap and redirect: the trap wins and the redirect is dropped.
- A redirect coincident with a transfer: the redirect wins; the transfer still counts.
- Misaligned trap or redirect target:
  - The PC is not updated.
  - misalign_err pulses high the next cycle and bad_addr <= the target.
  - If the trap target is misaligned, a valid redirect in the same cycle is also ignored.
- Halt:
  - halt_req in RUN enters HALT at the next edge, but only if no request is pending (fetch_valid && !fetch_ready); otherwise entry waits until the transfer completes.
  - resume in HALT returns to RUN next edge; resume has priority over halt_req.
  - Traps and redirects update fetch_pc while in HALT, so a debugger can set the PC.
- fetch_count increments by 1 per transfer and wraps at 2^CNT_W.
- Reset asserted mid-operation immediately restores all reset values, including a pending transfer.

Optional Feature:
- Macro RVC_EN.
- Defined:
  - Alignment is 2 bytes (target[0]==0).
  - Step is 2 when is_compressed=1, otherwise 4.
- Undefined:
  - Alignment is 4 bytes (target[1:0]==0).
  - Step is always 4 and is_compressed is ignored.

Test Plan:
- Reset release with RESET_VECTOR=0, fetch_ready=1 -> fetch_valid=0 for 1 cycle; fetch_pc then 0,4,8,C on successive cycles; fetch_count=4.
- fetch_pc=FFFF_FFF8, fetch_ready=1 for 3 cycles -> fetch_pc = FFFF_FFFC, 0000_0000, 0000_0004; misalign_err stays 0.
- fetch_ready=0 for 3 cycles at fetch_pc=10 -> fetch_pc holds 10 and fetch_count is unchanged; same-cycle redirect_target=40 -> next fetch_pc=40.
- trap_valid(vector=100) and redirect_valid(target=200) in the same cycle -> fetch_pc=100.
- redirect_target=0000_0042 without RVC_EN -> fetch_pc unchanged, misalign_err=1 for 1 cycle, bad_addr=42; with RVC_EN and target=42 -> fetch_pc=42, then 44 with is_compressed=1.
- halt_req while fetch_ready=0 -> stays in RUN until the transfer completes, then halted=1 and fetch_valid=0; redirect to 80 while halted -> fetch_pc=80; resume -> fetch_valid=1 at 80.
